// File: rtl/bsw_job_scheduler.sv
// ---------------------------------------------------------------------------
// bsw_job_scheduler
//   Sequences a banded Smith-Waterman accelerator one job at a time.
//   A request (R/Q subsequences + tag) is accepted in IDLE. The accelerator's
//   active-high start (its reset) is held for START_CYCLES cycles. R/Q are then
//   kept stable through fill and traceback. The aligned outputs are captured
//   when the accelerator flags ready. A watchdog aborts a job that stays in RUN
//   for TIMEOUT_CYC cycles. Results are returned over a valid/ready port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   job_valid/job_ready      request handshake
//   job_r, job_q, job_tag    request payload (3*L, 3*L, TAG_W bits)
//   acc_start                accelerator start/reset (high outside RUN)
//   acc_r, acc_q             subsequences presented to the accelerator
//   acc_ready                accelerator traceback finished
//   acc_r/q_aligned          accelerator alignment outputs (3*L+6 bits)
//   res_valid/res_ready      result handshake
//   res_r/q_aligned, res_tag captured result payload
//   res_err                  1 = job aborted by the watchdog
//   busy                     scheduler not in IDLE
//
// Optional build macro BSW_SCHED_STATS_EN adds stat_jobs / stat_timeouts
// (16-bit saturating counters of completed jobs / watchdog aborts).
// ---------------------------------------------------------------------------
module bsw_job_scheduler #(
  parameter int L            = 8,
  parameter int TAG_W        = 4,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [3*L-1:0]     job_r,
  input  logic [3*L-1:0]     job_q,
  input  logic [TAG_W-1:0]   job_tag,
  output logic               acc_start,
  output logic [3*L-1:0]     acc_r,
  output logic [3*L-1:0]     acc_q,
  input  logic               acc_ready,
  input  logic [3*L+5:0]     acc_r_aligned,
  input  logic [3*L+5:0]     acc_q_aligned,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [3*L+5:0]     res_r_aligned,
  output logic [3*L+5:0]     res_q_aligned,
  output logic [TAG_W-1:0]   res_tag,
  output logic               res_err,
  output logic               busy
`ifdef BSW_SCHED_STATS_EN
  ,
  output logic [15:0]        stat_jobs,
  output logic [15:0]        stat_timeouts
`endif
);

  localparam int RW = 3*L;
  localparam int AW = 3*L+6;

  localparam logic [7:0] START_LAST = 8'(START_CYCLES - 1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_cnt;
  logic [RW-1:0]      r_acc_r;
  logic [RW-1:0]      r_acc_q;
  logic [TAG_W-1:0]   r_tag;
  logic [AW-1:0]      r_res_r;
  logic [AW-1:0]      r_res_q;
  logic [TAG_W-1:0]   r_res_tag;
  logic               r_res_err;
  logic               r_res_valid;

  logic               w_accept;
  logic               w_capture;
  logic               w_timeout;
  logic               w_release;
  logic               w_start_end;

  // Ready is qualified by a cnt>=2 guard so a ready left over from the
  // previous job (accelerator still coming out of reset) is not mistaken
  // for completion of this one.
  assign w_accept    = job_valid && job_ready;
  assign w_start_end = (r_state == START) && (r_cnt == START_LAST);
  assign w_capture   = (r_state == RUN) && acc_ready && (r_cnt >= 8'd2);
  assign w_timeout   = (r_state == RUN) && (r_cnt == TO_LAST);
  assign w_release   = (r_state == DONE) && res_ready;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)                w_state_nxt = START;
      START:   if (w_start_end)             w_state_nxt = RUN;
      RUN:     if (w_capture || w_timeout)  w_state_nxt = DONE;
      DONE:    if (w_release)               w_state_nxt = IDLE;
      default:                              w_state_nxt = IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    job_ready = 1'b0;
    acc_start = 1'b1;
    busy      = 1'b1;
    unique case (r_state)
      IDLE: begin
        job_ready = !rst;
        busy      = 1'b0;
      end
      START:   acc_start = 1'b1;
      RUN:     acc_start = 1'b0;
      DONE:    acc_start = 1'b1;
      default: acc_start = 1'b1;
    endcase
  end

  assign acc_r         = r_acc_r;
  assign acc_q         = r_acc_q;
  assign res_valid     = r_res_valid;
  assign res_r_aligned = r_res_r;
  assign res_q_aligned = r_res_q;
  assign res_tag       = r_res_tag;
  assign res_err       = r_res_err;

  // ---------------- cycle counter ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        START:   r_cnt <= w_start_end ? '0 : r_cnt + 8'd1;
        RUN:     r_cnt <= (w_capture || w_timeout) ? '0 : r_cnt + 8'd1;
        default: r_cnt <= '0;
      endcase
    end
  end

  // ---------------- job latch ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_r <= '0;
      r_acc_q <= '0;
      r_tag   <= '0;
    end else if (w_accept) begin
      r_acc_r <= job_r;
      r_acc_q <= job_q;
      r_tag   <= job_tag;
    end
  end

  // ---------------- result capture ----------------
  // Payload registers only change on capture/abort; res_valid alone drops
  // on consume so the last result stays readable afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_r     <= '0;
      r_res_q     <= '0;
      r_res_tag   <= '0;
      r_res_err   <= 1'b0;
      r_res_valid <= 1'b0;
    end else if (w_capture) begin
      r_res_r     <= acc_r_aligned;
      r_res_q     <= acc_q_aligned;
      r_res_tag   <= r_tag;
      r_res_err   <= 1'b0;
      r_res_valid <= 1'b1;
    end else if (w_timeout) begin
      r_res_r     <= '0;
      r_res_q     <= '0;
      r_res_tag   <= r_tag;
      r_res_err   <= 1'b1;
      r_res_valid <= 1'b1;
    end else if (w_release) begin
      r_res_valid <= 1'b0;
    end
  end

`ifdef BSW_SCHED_STATS_EN
  logic [15:0] r_stat_jobs;
  logic [15:0] r_stat_timeouts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_jobs     <= '0;
      r_stat_timeouts <= '0;
    end else if (w_release) begin
      if (r_stat_jobs != '1) begin
        r_stat_jobs <= r_stat_jobs + 16'd1;
      end
      if (r_res_err && (r_stat_timeouts != '1)) begin
        r_stat_timeouts <= r_stat_timeouts + 16'd1;
      end
    end
  end

  assign stat_jobs     = r_stat_jobs;
  assign stat_timeouts = r_stat_timeouts;
`endif

endmodule

// File: tb/tb_bsw_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bsw_job_scheduler
//   Self-checking bench for bsw_job_scheduler. Each job is described by its
//   payload, whether a stale ready is present in the first RUN cycle, the RUN
//   cycle at which the accelerator model raises ready (held), and how long the
//   consumer withholds res_ready. The expected outcome is derived from the
//   job-level rules: first qualifying ready at RUN cycle >= 2 wins, otherwise
//   the job aborts after TIMEOUT_CYC RUN cycles.
// ---------------------------------------------------------------------------
module tb_bsw_job_scheduler;

  localparam int L     = 8;
  localparam int TAG_W = 4;
  localparam int SC    = 2;
  localparam int TO    = 50;
  localparam int RW    = 3*L;
  localparam int AW    = 3*L+6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              job_valid = 1'b0;
  logic              job_ready;
  logic [RW-1:0]     job_r = '0;
  logic [RW-1:0]     job_q = '0;
  logic [TAG_W-1:0]  job_tag = '0;
  logic              acc_start;
  logic [RW-1:0]     acc_r;
  logic [RW-1:0]     acc_q;
  logic              acc_ready = 1'b0;
  logic [AW-1:0]     acc_r_aligned = '0;
  logic [AW-1:0]     acc_q_aligned = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [AW-1:0]     res_r_aligned;
  logic [AW-1:0]     res_q_aligned;
  logic [TAG_W-1:0]  res_tag;
  logic              res_err;
  logic              busy;
`ifdef BSW_SCHED_STATS_EN
  logic [15:0]       stat_jobs;
  logic [15:0]       stat_timeouts;
`endif

  bsw_job_scheduler #(
    .L(L), .TAG_W(TAG_W), .START_CYCLES(SC), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_r(job_r), .job_q(job_q), .job_tag(job_tag),
    .acc_start(acc_start), .acc_r(acc_r), .acc_q(acc_q),
    .acc_ready(acc_ready),
    .acc_r_aligned(acc_r_aligned), .acc_q_aligned(acc_q_aligned),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_r_aligned(res_r_aligned), .res_q_aligned(res_q_aligned),
    .res_tag(res_tag), .res_err(res_err), .busy(busy)
`ifdef BSW_SCHED_STATS_EN
    , .stat_jobs(stat_jobs), .stat_timeouts(stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Expected statistics (only compared when the feature is built in).
  int exp_jobs = 0;
  int exp_tos  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_stats();
`ifdef BSW_SCHED_STATS_EN
    chk("stat_jobs", 64'(stat_jobs), 64'(exp_jobs));
    chk("stat_timeouts", 64'(stat_timeouts), 64'(exp_tos));
`endif
  endtask

  // One complete job from IDLE back to IDLE.
  task automatic do_job(input logic [TAG_W-1:0] tag, input logic [RW-1:0] r,
                        input logic [RW-1:0] q, input bit stale,
                        input int ready_at, input int hold);
    bit            fin;
    bit            rdy;
    bit            exp_err;
    logic [AW-1:0] exp_r;
    logic [AW-1:0] exp_q;
    @(posedge clk); #1;
    job_valid = 1'b1; job_r = r; job_q = q; job_tag = tag;
    @(negedge clk);
    chk("idle_job_ready", 64'(job_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_acc_start", 64'(acc_start), 64'd1);
    @(posedge clk); #1;
    job_valid = 1'b0; job_r = RW'($urandom); job_q = RW'($urandom); job_tag = TAG_W'($urandom);
    for (int s = 0; s < SC; s++) begin
      @(negedge clk);
      chk("start_acc_start", 64'(acc_start), 64'd1);
      chk("start_busy", 64'(busy), 64'd1);
      chk("start_job_ready", 64'(job_ready), 64'd0);
      chk("start_acc_r", 64'(acc_r), 64'(r));
      chk("start_acc_q", 64'(acc_q), 64'(q));
      @(posedge clk); #1;
    end
    fin = 1'b0; exp_err = 1'b0; exp_r = '0; exp_q = '0;
    for (int k = 0; k < TO && !fin; k++) begin
      rdy = (stale && k == 0) || (ready_at >= 0 && k >= ready_at);
      acc_ready = rdy;
      acc_r_aligned = AW'({$urandom, $urandom});
      acc_q_aligned = AW'({$urandom, $urandom});
      @(negedge clk);
      chk("run_acc_start", 64'(acc_start), 64'd0);
      chk("run_res_valid", 64'(res_valid), 64'd0);
      chk("run_acc_r", 64'(acc_r), 64'(r));
      if (rdy && k >= 2) begin
        fin = 1'b1; exp_err = 1'b0; exp_r = acc_r_aligned; exp_q = acc_q_aligned;
      end else if (k == TO - 1) begin
        fin = 1'b1; exp_err = 1'b1; exp_r = '0; exp_q = '0;
      end
      @(posedge clk); #1;
    end
    acc_ready = 1'b0;
    acc_r_aligned = AW'({$urandom, $urandom});
    acc_q_aligned = AW'({$urandom, $urandom});
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) res_ready = 1'b1;
      @(negedge clk);
      chk("done_res_valid", 64'(res_valid), 64'd1);
      chk("done_res_r", 64'(res_r_aligned), 64'(exp_r));
      chk("done_res_q", 64'(res_q_aligned), 64'(exp_q));
      chk("done_res_tag", 64'(res_tag), 64'(tag));
      chk("done_res_err", 64'(res_err), 64'(exp_err));
      chk("done_acc_start", 64'(acc_start), 64'd1);
      chk("done_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    res_ready = 1'b0;
    exp_jobs++;
    if (exp_err) exp_tos++;
    @(negedge clk);
    chk("post_res_valid", 64'(res_valid), 64'd0);
    chk("post_job_ready", 64'(job_ready), 64'd1);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_res_r_held", 64'(res_r_aligned), 64'(exp_r));
    chk("post_res_tag_held", 64'(res_tag), 64'(tag));
    chk("post_acc_r_held", 64'(acc_r), 64'(r));
    chk_stats();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [RW-1:0] rr, qq;
    // ---- reset ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_job_ready", 64'(job_ready), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_job_ready_low", 64'(job_ready), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_acc_start", 64'(acc_start), 64'd1);
    chk("reset_res_valid", 64'(res_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_acc_r", 64'(acc_r), 64'd0);
    chk("reset_res_tag", 64'(res_tag), 64'd0);
    chk("reset_res_err", 64'(res_err), 64'd0);
    chk_stats();

    // ---- directed jobs ----
    do_job(4'h3, 24'h123456, 24'hABCDEF, 1'b0, 40, 5);   // normal completion
    do_job(4'h7, 24'h0F0F0F, 24'hF0F0F0, 1'b1, 9, 0);    // stale ready ignored
    do_job(4'h9, 24'h111111, 24'h222222, 1'b1, -1, 2);   // watchdog abort
    do_job(4'hA, 24'h333333, 24'h444444, 1'b0, TO-1, 1); // ready on timeout cycle
    do_job(4'hB, 24'h555555, 24'h666666, 1'b0, 1, 0);    // ready at cnt 1 then held
    do_job(4'hC, 24'h777777, 24'h888888, 1'b0, 2, 0);    // earliest legal ready

    // ---- randomized jobs ----
    for (int j = 0; j < 8; j++) begin
      do_job(TAG_W'($urandom), RW'($urandom), RW'($urandom),
             1'($urandom_range(0, 1)), int'($urandom_range(0, TO + 10)) - 1,
             int'($urandom_range(0, 4)));
    end

    // ---- reset mid-RUN, with a request pulse during START ----
    rr = RW'($urandom); qq = RW'($urandom);
    @(posedge clk); #1;
    job_valid = 1'b1; job_r = rr; job_q = qq; job_tag = 4'h5;
    @(posedge clk); #1;
    job_valid = 1'b1; job_r = ~rr; job_q = ~qq; job_tag = 4'h6;
    @(negedge clk);
    chk("start_pulse_job_ready", 64'(job_ready), 64'd0);
    @(posedge clk); #1;
    job_valid = 1'b0;
    @(negedge clk);
    chk("start_pulse_acc_r", 64'(acc_r), 64'(rr));
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrun_acc_start", 64'(acc_start), 64'd0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_jobs = 0; exp_tos = 0;
    @(negedge clk);
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    chk("abort_acc_start", 64'(acc_start), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_job_ready", 64'(job_ready), 64'd1);
    chk("abort_acc_r", 64'(acc_r), 64'd0);
    chk("abort_res_tag", 64'(res_tag), 64'd0);
    chk_stats();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_result", 64'(res_valid), 64'd0);
    end

    // ---- recovery after reset ----
    do_job(4'hE, RW'($urandom), RW'($urandom), 1'b0, 12, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
